discrete_filter_scheduler: RTL

DISCRETE_FILTER_SCHEDULER -- requirements
Module: discrete_filter_scheduler

---
 rtl/discrete_filter_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/discrete_filter_scheduler.sv
// Time-multiplexed first-order low-pass filter bank: y += alpha*(x-y) per channel per sample tick,
// with one shared multiplier, a snapshot of the inputs per pass and an atomic output update.
module discrete_filter_scheduler #(
  parameter int NUM_CH = 4
) (
  input  logic                   clk,
  input  logic                   I_RSTn,
  input  logic                   audio_clk_en,
  input  logic [NUM_CH-1:0]      ch_enable,
  input  logic [16*NUM_CH-1:0]   in_bus,
  input  logic [16*NUM_CH-1:0]   alpha_bus,
  input  logic                   overrun_clr,
  output logic [16*NUM_CH-1:0]   out_bus,
  output logic                   sample_valid,
  output logic                   busy,
  output logic                   overrun
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, MUL, ACC, DONE} state_t;

  state_t                 state_q;
  logic [CW-1:0]          ch_q;
  logic [NUM_CH-1:0]      en_q;
  logic [16*NUM_CH-1:0]   x_q;
  logic [16*NUM_CH-1:0]   a_q;
  logic [16*NUM_CH-1:0]   y_q;
  logic [16*NUM_CH-1:0]   y_d;
  logic [16*NUM_CH-1:0]   out_q;
  logic [15:0]            xo_q;
  logic [15:0]            yo_q;
  logic [15:0]            ao_q;
  logic signed [33:0]     p_q;
  logic                   sample_valid_q;
  logic                   overrun_q;

  logic signed [16:0]     d;
  logic signed [33:0]     d34;
  logic signed [33:0]     a34;
  logic signed [33:0]     prod;
  logic signed [33:0]     p_sh;
  logic signed [33:0]     y_ext;
  logic signed [33:0]     sum_w;
  logic [15:0]            y_new;
  logic                   y_wr;
  logic [15:0]            y_wr_val;
  logic                   last_ch;

  // The single shared multiplier: 17-bit signed difference times zero-extended Q0.16 alpha.
  assign d     = {xo_q[15], xo_q} - {yo_q[15], yo_q};
  assign d34   = {{17{d[16]}}, d};
  assign a34   = {18'd0, ao_q};
  assign prod  = d34 * a34;

  assign p_sh  = p_q >>> 16;
  assign y_ext = {{18{yo_q[15]}}, yo_q};
  assign sum_w = y_ext + p_sh;

  always_comb begin
    y_new = sum_w[15:0];
    if (sum_w > 34'sd32767)
      y_new = 16'h7fff;
    else if (sum_w < -34'sd32768)
      y_new = 16'h8000;
  end

  assign last_ch = (ch_q == CW'(NUM_CH - 1));

  // A state write happens either for a skipped channel (forced to zero) or on accumulate;
  // both also mark the end of that channel's slot.
  always_comb begin
    y_wr     = 1'b0;
    y_wr_val = '0;
    if (state_q == LOAD && !en_q[ch_q]) begin
      y_wr = 1'b1;
    end else if (state_q == ACC) begin
      y_wr     = 1'b1;
      y_wr_val = y_new;
    end
    y_d = y_q;
    if (y_wr)
      y_d[int'(ch_q)*16 +: 16] = y_wr_val;
  end

  always_ff @(posedge clk) begin
    if (!I_RSTn) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      en_q           <= '0;
      x_q            <= '0;
      a_q            <= '0;
      y_q            <= '0;
      out_q          <= '0;
      xo_q           <= '0;
      yo_q           <= '0;
      ao_q           <= '0;
      p_q            <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;

      if (audio_clk_en && state_q != IDLE)
        overrun_q <= 1'b1;
      else if (overrun_clr)
        overrun_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (audio_clk_en) begin
            x_q     <= in_bus;
            a_q     <= alpha_bus;
            en_q    <= ch_enable;
            ch_q    <= '0;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (en_q[ch_q]) begin
            xo_q    <= x_q[int'(ch_q)*16 +: 16];
            yo_q    <= y_q[int'(ch_q)*16 +: 16];
            ao_q    <= a_q[int'(ch_q)*16 +: 16];
            state_q <= MUL;
          end
        end
        MUL: begin
          p_q     <= prod;
          state_q <= ACC;
        end
        ACC: begin
          state_q <= LOAD;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase

      // Output is taken from y_d so the last channel's write lands in the same snapshot.
      if (y_wr) begin
        y_q <= y_d;
        if (last_ch) begin
          state_q        <= DONE;
          out_q          <= y_d;
          sample_valid_q <= 1'b1;
        end else begin
          ch_q    <= ch_q + CW'(1);
          state_q <= LOAD;
        end
      end
    end
  end

  assign out_bus      = out_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule
